// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type, default sizes and address-width helper
// for the multi-port register file.
package regfile_pkg;

    typedef enum logic {RF_INIT, RF_READY} rf_state_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port with write bypass,
// zero-register masking and masking while the clear sequence runs.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int AW       = 5,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [AW-1:0]       addr,
    input  logic [XLEN-1:0]     arr_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                busy,
    output logic [XLEN-1:0]     data
);

    // Ascending loop: the highest matching write port overrides lower ones.
    always_comb begin
        data = arr_data;
        for (int j = 0; j < NWR; j++)
            if (BYPASS != 0 && wr_en[j] && wr_addr[j*AW +: AW] == addr)
                data = wr_data[j*XLEN +: XLEN];
        if (busy || (ZERO_REG != 0 && addr == '0))
            data = '0;
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with prioritised writes,
// optional bypass and a post-reset clear sequencer that stalls the pipeline.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    input  logic [NWR-1:0]      wr_en_i,
    input  logic [NWR*AW-1:0]   wr_addr_i,
    input  logic [NWR*XLEN-1:0] wr_data_i,
    output logic                init_busy_o
);

    localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

    rf_state_e       state, state_nx;
    logic [AW:0]     cnt;
    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == RF_INIT)
                cnt <= cnt + (AW+1)'(1);
        end
    end

    always_comb begin
        state_nx = state;
        if (state == RF_INIT && cnt == LAST)
            state_nx = RF_READY;
    end

    assign init_busy_o = (state == RF_INIT);

    // Array has no reset: the clear sequencer zeroes it, and reads are masked meanwhile.
    always_ff @(posedge clk) begin
        if (init_busy_o)
            mem[cnt[AW-1:0]] <= '0;
        else
            for (int j = 0; j < NWR; j++)
                if (wr_en_i[j] && !(ZERO_REG != 0 && wr_addr_i[j*AW +: AW] == '0))
                    mem[wr_addr_i[j*AW +: AW]] <= wr_data_i[j*XLEN +: XLEN];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        rf_read_port #(
            .XLEN    (XLEN),
            .AW      (AW),
            .NWR     (NWR),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd (
            .addr    (rd_addr_i[k*AW +: AW]),
            .arr_data(mem[rd_addr_i[k*AW +: AW]]),
            .wr_en   (wr_en_i),
            .wr_addr (wr_addr_i),
            .wr_data (wr_data_i),
            .busy    (init_busy_o),
            .data    (rd_data_o[k*XLEN +: XLEN])
        );
    end

endmodule
